// File: rtl/tl_pkg.sv
// Shared definitions for the N-phase traffic-light sequencer:
// state codes, mode-key encodings and the phase wrap helper.
package tl_pkg;

    typedef enum logic [1:0] {
        ST_NIGHT  = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_ALLRED = 2'd3
    } tl_state_e;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_SETG  = 2'b10;
    localparam logic [1:0] MODE_SETY  = 2'b11;

    // Next phase index; wraps from the last phase back to 0.
    function automatic logic [3:0] ph_next(
        input logic [3:0] ph,
        input logic [3:0] last
    );
        return (ph == last) ? 4'd0 : ph + 4'd1;
    endfunction

endpackage

// File: rtl/tl_time_reg.sv
// Saturating up/down time register used for green and yellow times.
// Ports: clk, rst (sync, active-high), en_i, inc_i, dec_i, val_o.
module tl_time_reg #(
    parameter int           W       = 11,
    parameter logic [W-1:0] RST_VAL = W'(1),
    parameter logic [W-1:0] MIN_VAL = W'(1),
    parameter logic [W-1:0] MAX_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] val_o
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    // Simultaneous inc and dec cancel out.
    always_comb begin
        val_d = val_q;
        if (en_i && inc_i && !dec_i && (val_q < MAX_VAL)) begin
            val_d = val_q + W'(1);
        end else if (en_i && dec_i && !inc_i && (val_q > MIN_VAL)) begin
            val_d = val_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/tl_phase_sequencer.sv
// N-phase GREEN/YELLOW/ALL-RED sequencer with night flash, time setting
// and phase preemption.
// Ports: clk, rst, tick, mode, inc, dec, pre_req, pre_ph in;
//        lamp_r/y/g, cnt, cur_ph, st, g_time, y_time out.
module tl_phase_sequencer
    import tl_pkg::*;
#(
    parameter int N_PH     = 4,
    parameter int CNT_W    = 11,
    parameter int G_DEF    = 8,
    parameter int Y_DEF    = 6,
    parameter int AR_TIME  = 1,
    parameter int PRE_TIME = 5,
    localparam int PH_W    = (N_PH > 1) ? $clog2(N_PH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [1:0]       mode,
    input  logic             inc,
    input  logic             dec,
    input  logic             pre_req,
    input  logic [PH_W-1:0]  pre_ph,
    output logic [N_PH-1:0]  lamp_r,
    output logic [N_PH-1:0]  lamp_y,
    output logic [N_PH-1:0]  lamp_g,
    output logic [CNT_W-1:0] cnt,
    output logic [PH_W-1:0]  cur_ph,
    output logic [1:0]       st,
    output logic [CNT_W-1:0] g_time,
    output logic [CNT_W-1:0] y_time
);

    localparam logic [CNT_W-1:0] AR_C  = CNT_W'(AR_TIME);
    localparam logic [CNT_W-1:0] PRE_C = CNT_W'(PRE_TIME);
    localparam logic [PH_W-1:0]  LAST  = PH_W'(N_PH - 1);

    tl_state_e        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             flash_q, flash_d;
    logic             pend_v_q, pend_v_d;
    logic [PH_W-1:0]  pend_ph_q, pend_ph_d;

    logic             pre_ok;
    logic             expire;
    logic [PH_W-1:0]  wrap_ph;

    tl_time_reg #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(G_DEF))
    ) u_g_time (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mode == MODE_SETG),
        .inc_i (inc),
        .dec_i (dec),
        .val_o (g_time)
    );

    tl_time_reg #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(Y_DEF))
    ) u_y_time (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mode == MODE_SETY),
        .inc_i (inc),
        .dec_i (dec),
        .val_o (y_time)
    );

    // Out-of-range targets are dropped, so N_PH need not be 2^k.
    assign pre_ok  = pre_req && (32'(pre_ph) < N_PH);
    assign expire  = tick && (cnt_q == CNT_W'(1));
    assign wrap_ph = PH_W'(ph_next(4'(ph_q), 4'(LAST)));

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        flash_d   = flash_q;
        pend_v_d  = pend_v_q;
        pend_ph_d = pend_ph_q;
        if (mode == MODE_NIGHT) begin
            st_d     = ST_NIGHT;
            cnt_d    = '0;
            pend_v_d = 1'b0;
            flash_d  = (st_q == ST_NIGHT) ? (flash_q ^ tick) : 1'b1;
        end else if (st_q == ST_NIGHT) begin
            // Restart so the first green after night is phase 0.
            st_d  = ST_ALLRED;
            cnt_d = AR_C;
            ph_d  = LAST;
        end else if (mode == MODE_RUN) begin
            unique case (1'b1)
                (st_q == ST_GREEN): begin
                    if (pre_ok && (pre_ph != ph_q)) begin
                        st_d      = ST_YELLOW;
                        cnt_d     = PRE_C;
                        pend_v_d  = 1'b1;
                        pend_ph_d = pre_ph;
                    end else if (pre_ok) begin
                        cnt_d = g_time;
                    end else if (expire) begin
                        st_d  = ST_YELLOW;
                        cnt_d = y_time;
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                (st_q == ST_YELLOW): begin
                    if (pre_ok) begin
                        pend_v_d  = 1'b1;
                        pend_ph_d = pre_ph;
                    end
                    if (expire) begin
                        st_d  = ST_ALLRED;
                        cnt_d = AR_C;
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                (st_q == ST_ALLRED): begin
                    if (pre_ok) begin
                        pend_v_d  = 1'b1;
                        pend_ph_d = pre_ph;
                    end
                    if (expire) begin
                        // A request arriving on this very edge is the latest.
                        st_d     = ST_GREEN;
                        cnt_d    = g_time;
                        pend_v_d = 1'b0;
                        if (pre_ok) begin
                            ph_d = pre_ph;
                        end else if (pend_v_q) begin
                            ph_d = pend_ph_q;
                        end else begin
                            ph_d = wrap_ph;
                        end
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= ST_ALLRED;
            cnt_q     <= AR_C;
            ph_q      <= LAST;
            flash_q   <= 1'b1;
            pend_v_q  <= 1'b0;
            pend_ph_q <= '0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            flash_q   <= flash_d;
            pend_v_q  <= pend_v_d;
            pend_ph_q <= pend_ph_d;
        end
    end

    logic [N_PH-1:0] sel;
    assign sel = N_PH'(1) << ph_q;

    always_comb begin
        lamp_r = '0;
        lamp_y = '0;
        lamp_g = '0;
        unique case (1'b1)
            (st_q == ST_NIGHT): begin
                lamp_y = {N_PH{flash_q}};
            end
            (st_q == ST_GREEN): begin
                lamp_g = sel;
                lamp_r = ~sel;
            end
            (st_q == ST_YELLOW): begin
                lamp_y = sel;
                lamp_r = ~sel;
            end
            default: begin
                lamp_r = '1;
            end
        endcase
    end

    assign cnt    = cnt_q;
    assign cur_ph = ph_q;
    assign st     = st_q;

endmodule

// File: doc/tl_phase_sequencer.md
Name: tl_phase_sequencer

Overview:
Parametrised N-phase traffic-light sequencer, the successor of the fixed two-group controller. Cycles GREEN -> YELLOW -> ALL-RED through N_PH phases, with programmable green/yellow times, a night-flash mode and a preemption request that jumps to a chosen phase. Sits between the 1 s tick generator and the key debouncers (upstream) and the lamp drivers, 74HC595 and 7-segment display path (downstream).

Parameters:
N_PH, 4, number of phases/approaches (2..16, need not be a power of 2)
CNT_W, 11, width of countdown and time registers
G_DEF, 8, reset green time in ticks
Y_DEF, 6, reset yellow time in ticks
AR_TIME, 1, all-red clearance time in ticks (>=1)
PRE_TIME, 5, yellow time applied on a preemption (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle strobe, 1 Hz
mode  in  2  00 run, 01 night, 10 set green time, 11 set yellow time
inc  in  1  one-cycle key pulse
dec  in  1  one-cycle key pulse
pre_req  in  1  one-cycle preemption request
pre_ph  in  PH_W=max(1,$clog2(N_PH))  target phase for pre_req
lamp_r  out  N_PH  red lamp per phase
lamp_y  out  N_PH  yellow lamp per phase
lamp_g  out  N_PH  green lamp per phase
cnt  out  CNT_W  remaining ticks in current state
cur_ph  out  PH_W  active phase
st  out  2  current FSM state code
g_time  out  CNT_W  programmed green time
y_time  out  CNT_W  programmed yellow time

Behaviour:
- Single clock `clk`; reset `rst` is synchronous, active-high.
- Reset:
  - st=ALLRED, cnt=AR_TIME, cur_ph=N_PH-1, so the first green is phase 0.
  - g_time=G_DEF, y_time=Y_DEF, pending preempt cleared, flash=1.
  - Lamps: lamp_r all ones, lamp_y=0, lamp_g=0.
- States:
  - NIGHT: lamp_y = {N_PH{flash}}, r=g=0.
  - GREEN: g[cur_ph]=1, every other phase red.
  - YELLOW: y[cur_ph]=1, others red.
  - ALLRED: all red.
- Lamps are a combinational decode of registered st/cur_ph/flash; zero added latency.
- Countdown:
  - In run mode, on tick with cnt>1: cnt decrements.
  - On tick with cnt==1: transition on the same edge and load the new state's time.
  - Each state therefore lasts exactly its programmed tick count.
- Transitions and loads:
  - GREEN -> YELLOW, loads y_time.
  - YELLOW -> ALLRED, loads AR_TIME.
  - ALLRED -> GREEN, loads g_time. New cur_ph is the pending target if one is set (then cleared), else cur_ph+1, wrapping N_PH-1 -> 0.
- mode 10/11:
  - FSM and cnt are frozen; ticks and pre_req are ignored.
  - inc adds 1 and dec subtracts 1 from g_time (10) or y_time (11), saturating at 1 and 2^CNT_W-1.
  - inc and dec in the same cycle: no change.
  - New values take effect at the next load; cnt is not retimed.
- mode 01, from any state:
  - Next edge: st=NIGHT, cnt=0, flash=1, pending cleared.
  - flash toggles on each tick.
  - Leaving night (mode!=01): st=ALLRED, cnt=AR_TIME, cur_ph=N_PH-1.
- Preemption (run mode only; pre_ph>=N_PH ignored):
  - GREEN, pre_ph!=cur_ph: -> YELLOW with cnt=PRE_TIME, pending=pre_ph.
  - GREEN, pre_ph==cur_ph: cnt reloaded with g_time (extension).
  - YELLOW/ALLRED: pending=pre_ph; the latest request wins; no change to cnt.
  - Same cycle as GREEN expiry (tick, cnt==1, different phase): -> YELLOW loaded with PRE_TIME, pending latched.
- Reset has priority over everything and takes effect mid-state on the next edge.
- st codes: 0 NIGHT, 1 GREEN, 2 YELLOW, 3 ALLRED.

Decomposition:
- Package tl_pkg:
  - state enum (NIGHT/GREEN/YELLOW/ALLRED codes)
  - mode encodings (MODE_RUN/NIGHT/SETG/SETY)
  - helper function for the phase wrap increment.
- Sub-module tl_time_reg: saturating up/down register with enable, reset value parameter, min/max clamp. Instantiated twice, for g_time and y_time.

Test Plan:
1. N_PH=3, G=3, Y=2, AR=1; release rst, mode=00, tick every 10 cycles -> ALLRED 1, G ph0 3, Y ph0 2, AR 1, G ph1 ..., G ph2 -> AR -> G ph0 (wrap); cnt sequence 3,2,1 in green.
2. GREEN ph0 at cnt=3, pre_req with pre_ph=2 -> next edge YELLOW ph0 cnt=5, then ALLRED, then GREEN ph2; pre_ph=0 during GREEN ph0 -> cnt reloaded to 3; pre_ph=3 -> ignored.
3. mode=01 mid-GREEN -> NIGHT next edge, lamp_y=111 then toggling 000/111 per tick; mode=00 -> ALLRED cnt=1, then GREEN ph0.
4. mode=10, three inc pulses -> g_time 8->11; inc+dec same cycle -> unchanged; g_time=1 plus dec -> stays 1; ticks while in set mode -> cnt frozen.
5. GREEN ph1, tick with cnt==1 in the same cycle as pre_req pre_ph=0 -> YELLOW cnt=PRE_TIME, then GREEN ph0 after ALLRED.
6. Assert rst during YELLOW -> next edge ALLRED, cnt=AR_TIME, lamp_r all ones, g_time/y_time back to defaults.
